// File: rtl/regfile_scb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_scb_pkg
// Shared definitions for the decode-stage register file and its pending
// scoreboard: default geometry, the hard-wired zero register index, and
// default-width address/data types.
// Ports: none (package).
// ---------------------------------------------------------------------------
package regfile_scb_pkg;

    localparam int DEF_N     = 64;
    localparam int DEF_REGS  = 32;
    localparam int DEF_NREAD = 2;
    localparam int XZR_IDX   = 31;

    typedef logic [$clog2(DEF_REGS)-1:0] reg_addr_t;
    typedef logic [DEF_N-1:0]            reg_data_t;

    // A register can hold state (be written or marked pending) only if it
    // exists and is not the hard-wired zero register.
    function automatic logic addr_writable(input int addr, input int regs, input int zero_reg);
        return (addr < regs) && (addr != zero_reg);
    endfunction

endpackage

// File: rtl/regfile_scb_if.sv
// ---------------------------------------------------------------------------
// regfile_scb_if
// Bundles the writeback, read and issue/flush signals of regfile_scb.
//   master : decode/writeback side (drives we3/wa3/wd3, ra, issue_en/issue_rd,
//            flush; receives rd, pend)
//   slave  : the register file itself
// ---------------------------------------------------------------------------
interface regfile_scb_if
    import regfile_scb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int AW    = $clog2(DEF_REGS),
    parameter int NREAD = DEF_NREAD
) ();

    logic                  we3;
    logic [AW-1:0]         wa3;
    logic [N-1:0]          wd3;
    logic [NREAD*AW-1:0]   ra;
    logic [NREAD*N-1:0]    rd;
    logic [NREAD-1:0]      pend;
    logic                  issue_en;
    logic [AW-1:0]         issue_rd;
    logic                  flush;

    modport master (
        output we3, wa3, wd3, ra, issue_en, issue_rd, flush,
        input  rd, pend
    );

    modport slave (
        input  we3, wa3, wd3, ra, issue_en, issue_rd, flush,
        output rd, pend
    );

endinterface

// File: rtl/regfile_scb_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// One pending bit per architectural register. Decode sets a bit when it
// issues an instruction targeting that register; writeback clears it; flush
// clears everything. NREAD combinational lookups report the raw bits.
// Ports:
//   clk, reset   clock / asynchronous active-low reset
//   clr_en/addr  writeback clear (caller guarantees addr is writable)
//   issue_en/rd  decode issue of a destination tag
//   flush        clear all bits, wins over a same-cycle issue
//   look_addr    NREAD packed lookup addresses
//   look_pend    NREAD raw pending bits
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_scb_pkg::*;
#(
    parameter int REGS     = DEF_REGS,
    parameter int NREAD    = DEF_NREAD,
    parameter int ZERO_REG = XZR_IDX,
    parameter int AW       = $clog2(REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    input  logic                flush,
    input  logic [NREAD*AW-1:0] look_addr,
    output logic [NREAD-1:0]    look_pend
);

    logic [REGS-1:0] pending_q;
    logic            set_ok;

    // The zero register and out-of-range tags are never marked pending,
    // which keeps their bits permanently 0.
    assign set_ok = issue_en && addr_writable(int'(issue_rd), REGS, ZERO_REG);

    // The set is ordered after the clear so that an issue and a writeback to
    // the same register in one cycle leaves the bit set for the new producer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else if (flush) begin
            pending_q <= '0;
        end else begin
            if (clr_en) begin
                pending_q[clr_addr] <= 1'b0;
            end
            if (set_ok) begin
                pending_q[issue_rd] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_look
        logic [AW-1:0] addr;
        assign addr = look_addr[k*AW +: AW];
        assign look_pend[k] = (int'(addr) < REGS) ? pending_q[addr] : 1'b0;
    end

endmodule

// File: rtl/regfile_scb.sv
// ---------------------------------------------------------------------------
// regfile_scb
// Parametrised decode-stage register file with optional writeback->read
// bypass and a per-register pending scoreboard for hazard detection.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  asynchronous active-low reset (reg[i] = i, zero reg = 0, no pending)
//   bus    regfile_scb_if.slave: writeback (we3/wa3/wd3), NREAD read ports
//          (ra -> rd, pend), issue (issue_en/issue_rd), flush
// ---------------------------------------------------------------------------
module regfile_scb
    import regfile_scb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int REGS     = DEF_REGS,
    parameter int NREAD    = DEF_NREAD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = XZR_IDX
) (
    input  logic           clk,
    input  logic           reset,
    regfile_scb_if.slave   bus
);

    localparam int AW = $clog2(REGS);

    logic [N-1:0]     regs_q [REGS];
    logic             write_ok;
    logic [NREAD-1:0] sb_pend;

    // Writes to the zero register or to a non-existent register are dropped.
    assign write_ok = bus.we3 && addr_writable(int'(bus.wa3), REGS, ZERO_REG);

    // Reset seeds each register with its own index so a freshly reset core
    // has recognisable contents; the zero register holds 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= (i == ZERO_REG) ? '0 : N'(i);
            end
        end else if (write_ok) begin
            regs_q[bus.wa3] <= bus.wd3;
        end
    end

    regfile_scoreboard #(
        .REGS     (REGS),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .clr_en    (write_ok),
        .clr_addr  (bus.wa3),
        .issue_en  (bus.issue_en),
        .issue_rd  (bus.issue_rd),
        .flush     (bus.flush),
        .look_addr (bus.ra),
        .look_pend (sb_pend)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0] addr;
        logic          valid;
        logic          hit;
        logic [N-1:0]  rd_k;

        assign addr  = bus.ra[k*AW +: AW];
        assign valid = addr_writable(int'(addr), REGS, ZERO_REG);
        // A writeback landing this cycle is already the architectural value
        // from the reader's point of view, so it also retires the hazard.
        assign hit   = (BYPASS != 0) && write_ok && (bus.wa3 == addr);

        always_comb begin
            rd_k = '0;
            if (valid) begin
                rd_k = hit ? bus.wd3 : regs_q[addr];
            end
        end

        assign bus.rd[k*N +: N] = rd_k;
        assign bus.pend[k]      = valid && !hit && sb_pend[k];
    end

endmodule

// File: tb/tb_regfile_scb.sv
// ---------------------------------------------------------------------------
// tb_regfile_scb
// Three instances: 32x64 with bypass (a), 32x64 without bypass (b), and
// 16x32 with three read ports and the zero register disabled (c). A
// behavioural model of register contents and pending flags is checked
// against every read port on every falling edge; directed literal checks
// pin the model's behaviour on the interesting cases.
// ---------------------------------------------------------------------------
module tb_regfile_scb;

    logic       clk;
    logic       reset;
    logic       we3;
    logic [7:0] wa3;
    logic [63:0] wd3;
    logic [7:0] ra [3];
    logic       issue_en;
    logic [7:0] issue_rd;
    logic       flush;

    int vectors;
    int miscompares;

    regfile_scb_if #(.N(64), .AW(5), .NREAD(2)) bus_a ();
    regfile_scb_if #(.N(64), .AW(5), .NREAD(2)) bus_b ();
    regfile_scb_if #(.N(32), .AW(4), .NREAD(3)) bus_c ();

    assign bus_a.we3      = we3;
    assign bus_a.wa3      = wa3[4:0];
    assign bus_a.wd3      = wd3;
    assign bus_a.ra       = {ra[1][4:0], ra[0][4:0]};
    assign bus_a.issue_en = issue_en;
    assign bus_a.issue_rd = issue_rd[4:0];
    assign bus_a.flush    = flush;

    assign bus_b.we3      = we3;
    assign bus_b.wa3      = wa3[4:0];
    assign bus_b.wd3      = wd3;
    assign bus_b.ra       = {ra[1][4:0], ra[0][4:0]};
    assign bus_b.issue_en = issue_en;
    assign bus_b.issue_rd = issue_rd[4:0];
    assign bus_b.flush    = flush;

    assign bus_c.we3      = we3;
    assign bus_c.wa3      = wa3[3:0];
    assign bus_c.wd3      = wd3[31:0];
    assign bus_c.ra       = {ra[2][3:0], ra[1][3:0], ra[0][3:0]};
    assign bus_c.issue_en = issue_en;
    assign bus_c.issue_rd = issue_rd[3:0];
    assign bus_c.flush    = flush;

    regfile_scb #(.N(64), .REGS(32), .NREAD(2), .BYPASS(1), .ZERO_REG(31)) u_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    regfile_scb #(.N(64), .REGS(32), .NREAD(2), .BYPASS(0), .ZERO_REG(31)) u_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );
    regfile_scb #(.N(32), .REGS(16), .NREAD(3), .BYPASS(1), .ZERO_REG(31)) u_c (
        .clk(clk), .reset(reset), .bus(bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: index 0 is the 32-register geometry (a and b), index 1 the
    // 16-register one (c). Zero register is 31 for both, so it only
    // matters for geometry 0.
    logic [63:0] m_reg  [2][32];
    bit          m_pend [2][32];

    function automatic int cfg_regs(input int c);
        return (c == 0) ? 32 : 16;
    endfunction

    function automatic int trunc_addr(input int c, input logic [7:0] x);
        return int'(x) % cfg_regs(c);
    endfunction

    function automatic bit is_valid(input int c, input int a);
        return (a < cfg_regs(c)) && (a != 31);
    endfunction

    function automatic logic [63:0] data_mask(input int c, input logic [63:0] d);
        return (c == 0) ? d : {32'h0, d[31:0]};
    endfunction

    function automatic bit bypass_hit(input int c, input int bypass, input int a);
        int w;
        w = trunc_addr(c, wa3);
        return (bypass != 0) && we3 && is_valid(c, w) && (w == a);
    endfunction

    function automatic logic [63:0] exp_rd(input int c, input int bypass, input int a);
        if (!is_valid(c, a)) return 64'h0;
        if (bypass_hit(c, bypass, a)) return data_mask(c, wd3);
        return m_reg[c][a];
    endfunction

    function automatic logic [63:0] exp_pend(input int c, input int bypass, input int a);
        if (!is_valid(c, a)) return 64'h0;
        if (bypass_hit(c, bypass, a)) return 64'h0;
        return {63'h0, m_pend[c][a]};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[c][i]  = (i == 31) ? 64'h0 : 64'(i);
                    m_pend[c][i] = 1'b0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                int w;
                int ir;
                w  = trunc_addr(c, wa3);
                ir = trunc_addr(c, issue_rd);
                if (we3 && is_valid(c, w)) m_reg[c][w] = data_mask(c, wd3);
                if (flush) begin
                    for (int i = 0; i < 32; i++) m_pend[c][i] = 1'b0;
                end else begin
                    if (we3 && is_valid(c, w)) m_pend[c][w] = 1'b0;
                    if (issue_en && is_valid(c, ir)) m_pend[c][ir] = 1'b1;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every read port of every instance is compared on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check_output("model_a_rd",   bus_a.rd[k*64 +: 64],    exp_rd(0, 1, trunc_addr(0, ra[k])));
            check_output("model_a_pend", 64'(bus_a.pend[k]),      exp_pend(0, 1, trunc_addr(0, ra[k])));
            check_output("model_b_rd",   bus_b.rd[k*64 +: 64],    exp_rd(0, 0, trunc_addr(0, ra[k])));
            check_output("model_b_pend", 64'(bus_b.pend[k]),      exp_pend(0, 0, trunc_addr(0, ra[k])));
        end
        for (int k = 0; k < 3; k++) begin
            check_output("model_c_rd",   64'(bus_c.rd[k*32 +: 32]), exp_rd(1, 1, trunc_addr(1, ra[k])));
            check_output("model_c_pend", 64'(bus_c.pend[k]),        exp_pend(1, 1, trunc_addr(1, ra[k])));
        end
    end

    task automatic apply_stimulus(
        input logic        t_we,
        input logic [7:0]  t_wa,
        input logic [63:0] t_wd,
        input logic [7:0]  t_r0,
        input logic [7:0]  t_r1,
        input logic [7:0]  t_r2,
        input logic        t_ie,
        input logic [7:0]  t_ir,
        input logic        t_fl
    );
        @(posedge clk);
        #1;
        we3      = t_we;
        wa3      = t_wa;
        wd3      = t_wd;
        ra[0]    = t_r0;
        ra[1]    = t_r1;
        ra[2]    = t_r2;
        issue_en = t_ie;
        issue_rd = t_ir;
        flush    = t_fl;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        we3      = 1'b0;
        wa3      = 8'd0;
        wd3      = 64'h0;
        ra[0]    = 8'd3;
        ra[1]    = 8'd31;
        ra[2]    = 8'd3;
        issue_en = 1'b0;
        issue_rd = 8'd0;
        flush    = 1'b0;

        // Reset state is visible combinationally while reset is held.
        #1 reset = 1'b0;
        #2;
        check_output("reset_rd_a",   bus_a.rd[63:0],    64'd3);
        check_output("reset_rd_xzr", bus_a.rd[127:64],  64'd0);
        check_output("reset_pend_a", 64'(bus_a.pend),   64'd0);

        // A write held under reset must not land.
        apply_stimulus(1'b1, 8'd4, 64'h1234, 8'd4, 8'd4, 8'd4, 1'b1, 8'd4, 1'b0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd4, 8'd4, 8'd4, 1'b0, 8'd0, 1'b0);
        reset = 1'b1;
        #1;
        check_output("reset_no_write", bus_b.rd[63:0], 64'd4);
        check_output("reset_no_issue", 64'(bus_b.pend), 64'd0);

        // Full read scan on all ports.
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(1'b0, 8'd0, 64'h0, 8'(i), 8'((i + 7) % 32), 8'(i), 1'b0, 8'd0, 1'b0);
            #1;
            check_output("scan_b_rd", bus_b.rd[63:0], (i == 31) ? 64'd0 : 64'(i));
        end

        // Write to 5: bypassed instance sees new data immediately.
        apply_stimulus(1'b1, 8'd5, 64'hDEAD_BEEF_0000_0001, 8'd5, 8'd5, 8'd5, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("bypass_a_rd5",  bus_a.rd[63:0], 64'hDEAD_BEEF_0000_0001);
        check_output("nobypass_b_rd5", bus_b.rd[63:0], 64'd5);
        check_output("bypass_c_rd5",  64'(bus_c.rd[31:0]), 64'h0000_0001);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd5, 8'd5, 8'd5, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("after_b_rd5", bus_b.rd[63:0], 64'hDEAD_BEEF_0000_0001);

        // Zero register ignores writes and issues (c sees register 15 instead).
        apply_stimulus(1'b1, 8'd31, 64'd1, 8'd31, 8'd31, 8'd31, 1'b1, 8'd31, 1'b0);
        #1;
        check_output("xzr_a_rd_write", bus_a.rd[127:0] == 128'h0 ? 64'd0 : 64'd1, 64'd0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd31, 8'd31, 8'd31, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("xzr_a_rd",   bus_a.rd[63:0],   64'd0);
        check_output("xzr_a_pend", 64'(bus_a.pend),  64'd0);
        check_output("c_rd15",     64'(bus_c.rd[31:0]), 64'd1);
        check_output("c_pend15",   64'(bus_c.pend),  64'd7);

        // Issue / writeback on register 7.
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd7, 8'd7, 8'd7, 1'b1, 8'd7, 1'b0);
        #1;
        check_output("issue7_not_yet", 64'(bus_a.pend), 64'd0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd7, 8'd7, 8'd7, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("issue7_a_pend", 64'(bus_a.pend), 64'd3);
        check_output("issue7_b_pend", 64'(bus_b.pend), 64'd3);
        apply_stimulus(1'b1, 8'd7, 64'h77, 8'd7, 8'd7, 8'd7, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("wb7_a_pend", 64'(bus_a.pend), 64'd0);
        check_output("wb7_b_pend", 64'(bus_b.pend), 64'd3);
        check_output("wb7_a_rd",   bus_a.rd[63:0],  64'h77);
        check_output("wb7_b_rd",   bus_b.rd[63:0],  64'd7);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd7, 8'd7, 8'd7, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("wb7_b_pend_after", 64'(bus_b.pend), 64'd0);
        check_output("wb7_b_rd_after",   bus_b.rd[63:0],  64'h77);
        apply_stimulus(1'b1, 8'd7, 64'h88, 8'd7, 8'd7, 8'd7, 1'b1, 8'd7, 1'b0);
        #1;
        check_output("both7_a_pend_now", 64'(bus_a.pend), 64'd0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd7, 8'd7, 8'd7, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("both7_a_pend", 64'(bus_a.pend), 64'd3);
        check_output("both7_b_rd",   bus_b.rd[63:0],  64'h88);

        // Flush beats a same-cycle issue.
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd1, 8'd4, 8'd2, 1'b1, 8'd1, 1'b0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd1, 8'd4, 8'd2, 1'b1, 8'd2, 1'b0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd1, 8'd4, 8'd2, 1'b1, 8'd3, 1'b0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd1, 8'd4, 8'd2, 1'b1, 8'd4, 1'b1);
        #1;
        check_output("preflush_a_pend", 64'(bus_a.pend), 64'd1);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd1, 8'd4, 8'd2, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("flush_a_pend", 64'(bus_a.pend), 64'd0);
        check_output("flush_b_pend", 64'(bus_b.pend), 64'd0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd2, 8'd3, 8'd3, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("flush_a_pend23", 64'(bus_a.pend), 64'd0);

        // Flush alongside a writeback still commits the data.
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd10, 8'd10, 8'd10, 1'b1, 8'd10, 1'b0);
        apply_stimulus(1'b1, 8'd10, 64'hAA, 8'd10, 8'd10, 8'd10, 1'b0, 8'd0, 1'b1);
        #1;
        check_output("flushwr_a_rd", bus_a.rd[63:0], 64'hAA);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd10, 8'd10, 8'd10, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("flushwr_b_rd",   bus_b.rd[63:0],  64'hAA);
        check_output("flushwr_b_pend", 64'(bus_b.pend), 64'd0);

        // Reset asserted between edges after writing register 9.
        apply_stimulus(1'b1, 8'd9, 64'hFF, 8'd9, 8'd9, 8'd9, 1'b1, 8'd9, 1'b0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd9, 8'd9, 8'd9, 1'b0, 8'd0, 1'b0);
        #1;
        check_output("pre_reset_b_rd9",   bus_b.rd[63:0],  64'hFF);
        check_output("pre_reset_a_pend9", 64'(bus_a.pend), 64'd3);
        #1 reset = 1'b0;
        #1;
        check_output("midreset_a_rd9",  bus_a.rd[63:0],    64'd9);
        check_output("midreset_b_rd9",  bus_b.rd[63:0],    64'd9);
        check_output("midreset_c_rd9",  64'(bus_c.rd[31:0]), 64'd9);
        check_output("midreset_a_pend", 64'(bus_a.pend),   64'd0);
        apply_stimulus(1'b1, 8'd9, 64'h123, 8'd9, 8'd9, 8'd9, 1'b1, 8'd9, 1'b0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd9, 8'd9, 8'd9, 1'b0, 8'd0, 1'b0);
        reset = 1'b1;
        #1;
        check_output("released_b_rd9",  bus_b.rd[63:0],  64'd9);
        check_output("released_a_pend", 64'(bus_a.pend), 64'd0);

        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd5, 8'd7, 8'd15, 1'b0, 8'd0, 1'b0);
        apply_stimulus(1'b0, 8'd0, 64'h0, 8'd0, 8'd30, 8'd0, 1'b0, 8'd0, 1'b0);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
